// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the hardwired control sequencer:
//   - opcode constants for the Phase-1 instruction set (ir[31:27])
//   - FSM state encoding (also exported on state_dbg)
//   - instruction class enum produced by opcode_classifier
//   - packed bundle of the datapath control strobes
// -----------------------------------------------------------------------------
package ctrl_pkg;

    localparam int OPCODE_W = 5;
    localparam int IR_W     = 32;

    // Opcode map
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    // FSM states; the numeric values are visible on state_dbg.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    // One bit per datapath strobe, driven as a group by the sequencer.
    typedef struct packed {
        logic pc_out;
        logic mar_enable;
        logic pc_increment;
        logic read;
        logic mdr_enable;
        logic mdr_out;
        logic ir_enable;
        logic y_enable;
        logic z_enable;
        logic zlo_out;
        logic zhi_out;
        logic lo_enable;
        logic hi_enable;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic c_out;
    } ctrl_strobes_t;

endpackage

// File: rtl/opcode_classifier.sv
// -----------------------------------------------------------------------------
// opcode_classifier
// Purely combinational decode of the 5-bit opcode into an instruction class
// and the ALU operation code presented during T4.
//
// Ports:
//   opcode_i       in   5  ir[31:27]
//   instr_class_o  out  3  instruction class (instr_class_e)
//   alu_op_o       out  5  ALU op: the opcode itself, except immediate forms
//                          which reuse their register-register counterpart
// -----------------------------------------------------------------------------
module opcode_classifier
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output instr_class_e        instr_class_o,
    output logic [OPCODE_W-1:0] alu_op_o
);

    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        instr_class_o = CLS_ILLEGAL;
        alu_op_o      = opcode_i;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: instr_class_o = CLS_R;
            OP_ADDI: begin
                instr_class_o = CLS_I;
                alu_op_o      = OP_ADD;
            end
            OP_ANDI: begin
                instr_class_o = CLS_I;
                alu_op_o      = OP_AND;
            end
            OP_ORI: begin
                instr_class_o = CLS_I;
                alu_op_o      = OP_OR;
            end
            OP_NEG, OP_NOT:  instr_class_o = CLS_UNARY;
            OP_MUL, OP_DIV:  instr_class_o = CLS_MULDIV;
            OP_NOP:          instr_class_o = CLS_NOP;
            OP_HALT:         instr_class_o = CLS_HALT;
            // ld/ldi/st need the memory write/address path, which this
            // block does not sequence; they fall in with unassigned codes.
            default:         instr_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired one-state-per-clock FSM that drives the Phase-1 datapath strobes
// through fetch (T0-T2), decode (T3) and execute (T4-T6). Outputs are Moore:
// decoded from the current state and ir only.
//
// Build option:
//   CTRL_ILLEGAL_TRAP_EN  defined   -> unknown/unsupported opcode in T3 sets
//                                      the sticky illegal_op flag and halts
//                         undefined -> such opcodes behave as nop and
//                                      illegal_op is tied low
//
// Ports:
//   clk            in   1    system clock, rising edge
//   clr            in   1    async active-low reset
//   run            in   1    fetch next instruction (IDLE / end of execute)
//   ir             in   IRW  instruction register contents
//   mem_ready      in   1    memory read data valid
//   pc_out, mar_enable, pc_increment                      out  fetch strobes
//   read, mdr_enable, mdr_out, ir_enable                  out  memory/IR
//   y_enable, z_enable, zlo_out, zhi_out, lo_enable,
//   hi_enable                                             out  ALU path
//   gra, grb, grc, r_in, r_out, c_out                     out  register fields
//   op_code        out  OPW  ALU operation (non-zero only in T4)
//   halted         out  1    FSM in HALT
//   illegal_op     out  1    sticky illegal-opcode trap flag
//   state_dbg      out  4    current state encoding
// -----------------------------------------------------------------------------
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPW = OPCODE_W,
    parameter int IRW = IR_W
)
(
    input  logic           clk,
    input  logic           clr,
    input  logic           run,
    input  logic [IRW-1:0] ir,
    input  logic           mem_ready,
    output logic           pc_out,
    output logic           mar_enable,
    output logic           pc_increment,
    output logic           read,
    output logic           mdr_enable,
    output logic           mdr_out,
    output logic           ir_enable,
    output logic           y_enable,
    output logic           z_enable,
    output logic           zlo_out,
    output logic           zhi_out,
    output logic           lo_enable,
    output logic           hi_enable,
    output logic           gra,
    output logic           grb,
    output logic           grc,
    output logic           r_in,
    output logic           r_out,
    output logic           c_out,
    output logic [OPW-1:0] op_code,
    output logic           halted,
    output logic           illegal_op,
    output logic [3:0]     state_dbg
);

    state_e          state_q, state_d;
    state_e          exit_state;
    ctrl_strobes_t   strb;
    instr_class_e    instr_class;
    logic [OPW-1:0]  alu_op;
    logic [OPW-1:0]  opcode;

    assign opcode = ir[IRW-1 -: OPW];

    // Operand fields below the opcode are decoded by the register
    // select/encode block, not here.
    logic unused_ir_low;
    assign unused_ir_low = ^ir[IRW-OPW-1:0];

    opcode_classifier u_classifier (
        .opcode_i      (opcode),
        .instr_class_o (instr_class),
        .alu_op_o      (alu_op)
    );

    // End-of-instruction exit shared by T3 (nop), T5 and T6.
    assign exit_state = run ? S_T0 : S_IDLE;

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        strb    = '0;
        op_code = '0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                strb.pc_out       = 1'b1;
                strb.mar_enable   = 1'b1;
                strb.pc_increment = 1'b1;
                state_d           = S_T1;
            end
            S_T1: begin
                // Read strobes are held for the whole stall.
                strb.read       = 1'b1;
                strb.mdr_enable = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                strb.mdr_out   = 1'b1;
                strb.ir_enable = 1'b1;
                state_d        = S_T3;
            end
            S_T3: begin
                case (instr_class)
                    CLS_HALT: state_d = S_HALT;
                    CLS_NOP:  state_d = exit_state;
                    CLS_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        state_d = exit_state;
`endif
                    end
                    default: begin
                        // Rb into Y is the first operand for every
                        // executing class.
                        strb.grb      = 1'b1;
                        strb.r_out    = 1'b1;
                        strb.y_enable = 1'b1;
                        state_d       = S_T4;
                    end
                endcase
            end
            S_T4: begin
                strb.z_enable = 1'b1;
                op_code       = alu_op;
                case (instr_class)
                    CLS_R: begin
                        strb.grc   = 1'b1;
                        strb.r_out = 1'b1;
                    end
                    CLS_I: begin
                        strb.c_out = 1'b1;
                    end
                    CLS_UNARY: begin
                        strb.grb   = 1'b1;
                        strb.r_out = 1'b1;
                    end
                    CLS_MULDIV: begin
                        strb.grc   = 1'b1;
                        strb.r_out = 1'b1;
                    end
                    default: ;
                endcase
                state_d = S_T5;
            end
            S_T5: begin
                strb.zlo_out = 1'b1;
                if (instr_class == CLS_MULDIV) begin
                    strb.lo_enable = 1'b1;
                    state_d        = S_T6;
                end else begin
                    strb.gra  = 1'b1;
                    strb.r_in = 1'b1;
                    state_d   = exit_state;
                end
            end
            S_T6: begin
                strb.zhi_out   = 1'b1;
                strb.hi_enable = 1'b1;
                state_d        = exit_state;
            end
            S_HALT: begin
                // Terminal until clr.
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Set on the T3 -> HALT transition of an illegal opcode; only clr clears.
    assign illegal_d = illegal_q
                     | ((state_q == S_T3) && (instr_class == CLS_ILLEGAL));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign halted    = (state_q == S_HALT);
    assign state_dbg = state_q;

    assign pc_out       = strb.pc_out;
    assign mar_enable   = strb.mar_enable;
    assign pc_increment = strb.pc_increment;
    assign read         = strb.read;
    assign mdr_enable   = strb.mdr_enable;
    assign mdr_out      = strb.mdr_out;
    assign ir_enable    = strb.ir_enable;
    assign y_enable     = strb.y_enable;
    assign z_enable     = strb.z_enable;
    assign zlo_out      = strb.zlo_out;
    assign zhi_out      = strb.zhi_out;
    assign lo_enable    = strb.lo_enable;
    assign hi_enable    = strb.hi_enable;
    assign gra          = strb.gra;
    assign grb          = strb.grb;
    assign grc          = strb.grc;
    assign r_in         = strb.r_in;
    assign r_out        = strb.r_out;
    assign c_out        = strb.c_out;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench: a per-cycle vector table of {run, mem_ready, ir} with the
// expected state, strobe set and op_code, followed by hand-written sequences
// for async clear during a fetch stall, illegal opcodes and halt.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    // Strobe bit positions in the observation word.
    localparam logic [18:0] PC_OUT  = 19'h40000;
    localparam logic [18:0] MAR_EN  = 19'h20000;
    localparam logic [18:0] PC_INC  = 19'h10000;
    localparam logic [18:0] READ    = 19'h08000;
    localparam logic [18:0] MDR_EN  = 19'h04000;
    localparam logic [18:0] MDR_OUT = 19'h02000;
    localparam logic [18:0] IR_EN   = 19'h01000;
    localparam logic [18:0] Y_EN    = 19'h00800;
    localparam logic [18:0] Z_EN    = 19'h00400;
    localparam logic [18:0] ZLO     = 19'h00200;
    localparam logic [18:0] ZHI     = 19'h00100;
    localparam logic [18:0] LO_EN   = 19'h00080;
    localparam logic [18:0] HI_EN   = 19'h00040;
    localparam logic [18:0] GRA     = 19'h00020;
    localparam logic [18:0] GRB     = 19'h00010;
    localparam logic [18:0] GRC     = 19'h00008;
    localparam logic [18:0] R_IN    = 19'h00004;
    localparam logic [18:0] R_OUT   = 19'h00002;
    localparam logic [18:0] C_OUT   = 19'h00001;

    localparam logic [18:0] F0  = PC_OUT | MAR_EN | PC_INC;
    localparam logic [18:0] F1  = READ | MDR_EN;
    localparam logic [18:0] F2  = MDR_OUT | IR_EN;
    localparam logic [18:0] DEC = GRB | R_OUT | Y_EN;

    localparam logic [31:0] IR_ROL  = 32'h421B8000;
    localparam logic [31:0] IR_MUL  = 32'h80000000;
    localparam logic [31:0] IR_ADDI = 32'h60000000;
    localparam logic [31:0] IR_ORI  = 32'h70000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_NEG  = 32'h88000000;
    localparam logic [31:0] IR_DIV  = 32'h78000000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic pc_out, mar_enable, pc_increment, read, mdr_enable, mdr_out, ir_enable;
    logic y_enable, z_enable, zlo_out, zhi_out, lo_enable, hi_enable;
    logic gra, grb, grc, r_in, r_out, c_out, halted, illegal_op;
    logic [4:0] op_code;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int bus_viol = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk          (clk),
        .clr          (clr),
        .run          (run),
        .ir           (ir),
        .mem_ready    (mem_ready),
        .pc_out       (pc_out),
        .mar_enable   (mar_enable),
        .pc_increment (pc_increment),
        .read         (read),
        .mdr_enable   (mdr_enable),
        .mdr_out      (mdr_out),
        .ir_enable    (ir_enable),
        .y_enable     (y_enable),
        .z_enable     (z_enable),
        .zlo_out      (zlo_out),
        .zhi_out      (zhi_out),
        .lo_enable    (lo_enable),
        .hi_enable    (hi_enable),
        .gra          (gra),
        .grb          (grb),
        .grc          (grc),
        .r_in         (r_in),
        .r_out        (r_out),
        .c_out        (c_out),
        .op_code      (op_code),
        .halted       (halted),
        .illegal_op   (illegal_op),
        .state_dbg    (state_dbg)
    );

    typedef struct {
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [3:0]  st;
        logic [18:0] strb;
        logic [4:0]  op;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic m, input logic [31:0] i,
                                input logic [3:0] s, input logic [18:0] b,
                                input logic [4:0] o);
        vec_t v;
        v.run = r; v.mr = m; v.ir = i; v.st = s; v.strb = b; v.op = o;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] obs();
        logic [18:0] s;
        s = {pc_out, mar_enable, pc_increment, read, mdr_enable, mdr_out, ir_enable,
             y_enable, z_enable, zlo_out, zhi_out, lo_enable, hi_enable,
             gra, grb, grc, r_in, r_out, c_out};
        return {2'b00, state_dbg, s, op_code, halted, illegal_op};
    endfunction

    function automatic logic [31:0] expv(input logic [3:0] st, input logic [18:0] b,
                                         input logic [4:0] o, input logic h,
                                         input logic il);
        return {2'b00, st, b, o, h, il};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Advance one clock and drive the next cycle's inputs just after the edge.
    task automatic cyc(input logic r, input logic m, input logic [31:0] i);
        @(posedge clk);
        #1;
        run = r; mem_ready = m; ir = i;
        #1;
    endtask

    // No two bus drivers may ever be active together.
    always @(negedge clk) begin
        if ($countones({pc_out, mdr_out, r_out, zlo_out, zhi_out, c_out}) > 1)
            bus_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rin_cnt;

        // rol, no stall: 6 cycles T0..T5, then straight into the next fetch
        add(1, 1, IR_ROL, 4'd0, '0, 5'd0);
        add(1, 1, IR_ROL, 4'd1, F0, 5'd0);
        add(1, 1, IR_ROL, 4'd2, F1, 5'd0);
        add(1, 1, IR_ROL, 4'd3, F2, 5'd0);
        add(1, 1, IR_ROL, 4'd4, DEC, 5'd0);
        add(1, 1, IR_ROL, 4'd5, Z_EN | GRC | R_OUT, 5'b01000);
        add(1, 1, IR_ROL, 4'd6, ZLO | GRA | R_IN, 5'd0);
        // mul with a 3-cycle fetch stall: T1 held 4 cycles
        add(1, 0, IR_MUL, 4'd1, F0, 5'd0);
        add(1, 0, IR_MUL, 4'd2, F1, 5'd0);
        add(1, 0, IR_MUL, 4'd2, F1, 5'd0);
        add(1, 0, IR_MUL, 4'd2, F1, 5'd0);
        add(1, 1, IR_MUL, 4'd2, F1, 5'd0);
        add(1, 1, IR_MUL, 4'd3, F2, 5'd0);
        add(1, 1, IR_MUL, 4'd4, DEC, 5'd0);
        add(1, 1, IR_MUL, 4'd5, Z_EN | GRC | R_OUT, 5'b10000);
        add(1, 1, IR_MUL, 4'd6, ZLO | LO_EN, 5'd0);
        add(1, 1, IR_MUL, 4'd7, ZHI | HI_EN, 5'd0);
        // addi, run dropped in T4: finishes, then IDLE
        add(1, 1, IR_ADDI, 4'd1, F0, 5'd0);
        add(1, 1, IR_ADDI, 4'd2, F1, 5'd0);
        add(1, 1, IR_ADDI, 4'd3, F2, 5'd0);
        add(1, 1, IR_ADDI, 4'd4, DEC, 5'd0);
        add(0, 1, IR_ADDI, 4'd5, Z_EN | C_OUT, 5'b00011);
        add(0, 1, IR_ADDI, 4'd6, ZLO | GRA | R_IN, 5'd0);
        // ori from IDLE
        add(1, 1, IR_ORI, 4'd0, '0, 5'd0);
        add(1, 1, IR_ORI, 4'd1, F0, 5'd0);
        add(1, 1, IR_ORI, 4'd2, F1, 5'd0);
        add(1, 1, IR_ORI, 4'd3, F2, 5'd0);
        add(1, 1, IR_ORI, 4'd4, DEC, 5'd0);
        add(1, 1, IR_ORI, 4'd5, Z_EN | C_OUT, 5'b00110);
        add(1, 1, IR_ORI, 4'd6, ZLO | GRA | R_IN, 5'd0);
        // nop: no strobes in T3, straight to T0
        add(1, 1, IR_NOP, 4'd1, F0, 5'd0);
        add(1, 1, IR_NOP, 4'd2, F1, 5'd0);
        add(1, 1, IR_NOP, 4'd3, F2, 5'd0);
        add(1, 1, IR_NOP, 4'd4, '0, 5'd0);
        // neg: unary, Rb on the bus in T4
        add(1, 1, IR_NEG, 4'd1, F0, 5'd0);
        add(1, 1, IR_NEG, 4'd2, F1, 5'd0);
        add(1, 1, IR_NEG, 4'd3, F2, 5'd0);
        add(1, 1, IR_NEG, 4'd4, DEC, 5'd0);
        add(1, 1, IR_NEG, 4'd5, Z_EN | GRB | R_OUT, 5'b10001);
        add(1, 1, IR_NEG, 4'd6, ZLO | GRA | R_IN, 5'd0);
        // div, then stop
        add(1, 1, IR_DIV, 4'd1, F0, 5'd0);
        add(1, 1, IR_DIV, 4'd2, F1, 5'd0);
        add(1, 1, IR_DIV, 4'd3, F2, 5'd0);
        add(1, 1, IR_DIV, 4'd4, DEC, 5'd0);
        add(1, 1, IR_DIV, 4'd5, Z_EN | GRC | R_OUT, 5'b01111);
        add(1, 1, IR_DIV, 4'd6, ZLO | LO_EN, 5'd0);
        add(0, 1, IR_DIV, 4'd7, ZHI | HI_EN, 5'd0);
        add(0, 1, IR_DIV, 4'd0, '0, 5'd0);
        add(0, 1, IR_DIV, 4'd0, '0, 5'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs(), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].run, vecs[i].mr, vecs[i].ir);
            check($sformatf("vec%0d", i), obs(),
                  expv(vecs[i].st, vecs[i].strb, vecs[i].op, 1'b0, 1'b0));
        end

        // clr asserted while stalled in T1
        cyc(1, 0, IR_ADDI);                       // IDLE
        cyc(1, 0, IR_ADDI);                       // T0
        cyc(1, 0, IR_ADDI);                       // T1
        cyc(1, 0, IR_ADDI);                       // T1 (stalled)
        check("stall_t1", obs(), expv(4'd2, F1, 5'd0, 1'b0, 1'b0));
        clr = 1'b0;
        #1;
        check("clr_async", obs(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        mem_ready = 1'b1;
        clr = 1'b1;
        rin_cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (r_in) rin_cnt++;
        end
        check("no_rin_after_clr", rin_cnt, 0);
        check("idle_after_clr", obs(), 32'd0);

        // Unknown opcode 11111
        cyc(1, 1, IR_BAD);                        // IDLE
        cyc(1, 1, IR_BAD);                        // T0
        cyc(1, 1, IR_BAD);                        // T1
        cyc(1, 1, IR_BAD);                        // T2
        cyc(1, 1, IR_BAD);                        // T3
        check("bad_t3", obs(), expv(4'd4, '0, 5'd0, 1'b0, 1'b0));
        cyc(1, 1, IR_BAD);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("bad_trap", obs(), expv(4'd8, '0, 5'd0, 1'b1, 1'b1));
        cyc(1, 1, IR_BAD);
        check("bad_trap_sticky", obs(), expv(4'd8, '0, 5'd0, 1'b1, 1'b1));
`else
        check("bad_as_nop", obs(), expv(4'd1, F0, 5'd0, 1'b0, 1'b0));
        cyc(1, 1, IR_BAD);
        check("bad_as_nop_t1", obs(), expv(4'd2, F1, 5'd0, 1'b0, 1'b0));
`endif
        clr = 1'b0;
        #1;
        check("clr_clears_flag", obs(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        clr = 1'b1;

        // halt
        cyc(1, 1, IR_HALT);                       // IDLE
        cyc(1, 1, IR_HALT);                       // T0
        cyc(1, 1, IR_HALT);                       // T1
        cyc(1, 1, IR_HALT);                       // T2
        cyc(1, 1, IR_HALT);                       // T3
        check("halt_t3", obs(), expv(4'd4, '0, 5'd0, 1'b0, 1'b0));
        cyc(1, 1, IR_HALT);
        check("halt_enter", obs(), expv(4'd8, '0, 5'd0, 1'b1, 1'b0));
        cyc(1, 1, IR_ROL);
        cyc(1, 1, IR_ROL);
        cyc(1, 1, IR_ROL);
        check("halt_stays", obs(), expv(4'd8, '0, 5'd0, 1'b1, 1'b0));
        clr = 1'b0;
        #1;
        check("halt_clr", obs(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_halt", obs(), 32'd0);

        check("bus_exclusive", bus_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
